// File: rtl/synth_seq_pkg.sv
// Shared definitions for the note step sequencer: note codes, FSM states,
// default timing parameters and the note-code to one-hot decode.
package synth_seq_pkg;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_C    = 4'h8;
    localparam logic [3:0] NOTE_D    = 4'h9;
    localparam logic [3:0] NOTE_E    = 4'hA;
    localparam logic [3:0] NOTE_F    = 4'hB;
    localparam logic [3:0] NOTE_G    = 4'hC;
    localparam logic [3:0] NOTE_A    = 4'hD;
    localparam logic [3:0] NOTE_B    = 4'hE;
    localparam logic [3:0] NOTE_C2   = 4'hF;

    localparam int TICK_DIV_DEFAULT  = 50000;
    localparam int GAP_TICKS_DEFAULT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_e;

    // bit3 marks a sounding note, bits 2:0 select which of the 8 synth keys
    function automatic logic [7:0] note_decode(input logic [3:0] code);
        note_decode = code[3] ? (8'h01 << code[2:0]) : 8'h00;
    endfunction

endpackage

// File: rtl/seq_tick_prescaler.sv
// Divides clk down to a 1-cycle tick every TICK_DIV enabled cycles.
// clear restarts the count so a fresh step begins on a full tick period.
module seq_tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int              CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            wrap;

    assign wrap   = enable_i && (cnt_q == CntMax);
    assign tick_o = wrap && !clear_i;

    // next count: clear wins, otherwise wrap at the top or advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_step_sequencer.sv
// Plays up to 16 stored note codes, one per tempo period, onto the synth's
// one-hot note input, with a silent gap at the end of each step so repeated
// notes produce a fresh rising edge.
module note_step_sequencer
    import synth_seq_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int GAP_TICKS = GAP_TICKS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en_i,
    input  logic [3:0] wr_addr_i,
    input  logic [3:0] wr_data_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       loop_en_i,
    input  logic [7:0] tempo_i,
    input  logic [3:0] len_i,
    output logic [7:0] note_out_o,
    output logic [3:0] step_idx_o,
    output logic       playing_o,
    output logic       step_strobe_o,
    output logic       done_o
);

    localparam logic [8:0] GapW = 9'(GAP_TICKS);

    seq_state_e state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] tick_cnt_q, tick_cnt_d;
    logic [7:0] period_q, period_d;
    logic [7:0] note_q, note_d;
    logic       strobe_q, strobe_d;
    logic       done_q, done_d;
    logic [3:0] mem_q [16];

    logic       tick;
    logic       start_go;
    logic       stop_go;
    logic       step_end;
    logic       audible;
    logic [7:0] tempo_eff;

    assign start_go  = start_i && !stop_i;
    assign stop_go   = stop_i && (state_q == PLAY);
    assign tempo_eff = (tempo_i == 8'd0) ? 8'd1 : tempo_i;
    assign step_end  = (state_q == PLAY) && tick && (tick_cnt_q == period_q - 8'd1);

    seq_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (start_go),
        .enable_i (state_q == PLAY),
        .tick_o   (tick)
    );

    // sequencing decisions: stop, then (re)start, then end of step, then tick count
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tick_cnt_d = tick_cnt_q;
        period_d   = period_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;
        if (stop_go) begin
            state_d = IDLE;
        end else if (start_go) begin
            state_d    = PLAY;
            step_d     = 4'd0;
            tick_cnt_d = 8'd0;
            period_d   = tempo_eff;
            strobe_d   = 1'b1;
        end else if (step_end) begin
            tick_cnt_d = 8'd0;
            if (step_q >= len_i) begin
                if (loop_en_i) begin
                    step_d   = 4'd0;
                    period_d = tempo_eff;
                    strobe_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                step_d   = step_q + 4'd1;
                period_d = tempo_eff;
                strobe_d = 1'b1;
            end
        end else if ((state_q == PLAY) && tick) begin
            tick_cnt_d = tick_cnt_q + 8'd1;
        end
    end

    // note for the coming cycle: sound unless in the trailing gap of a long enough step
    always_comb begin
        audible = ({1'b0, period_d} <= GapW) ||
                  (({1'b0, tick_cnt_d} + GapW) < {1'b0, period_d});
        note_d  = 8'h00;
        if ((state_d == PLAY) && audible) begin
            note_d = note_decode(mem_q[step_d]);
        end
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= 4'd0;
            tick_cnt_q <= 8'd0;
            period_q   <= 8'd0;
            note_q     <= 8'h00;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            tick_cnt_q <= tick_cnt_d;
            period_q   <= period_d;
            note_q     <= note_d;
            strobe_q   <= strobe_d;
            done_q     <= done_d;
        end
    end

    // pattern memory, writable at any time and cleared to rests on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= NOTE_REST;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign note_out_o    = note_q;
    assign step_idx_o    = step_q;
    assign playing_o     = (state_q == PLAY);
    assign step_strobe_o = strobe_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_note_step_sequencer.sv
// Testbench for note_step_sequencer: directed scenarios with fixed expected
// waveforms, then random traffic compared cycle by cycle against a reference
// model that tracks elapsed clocks per step.
module tb_note_step_sequencer;
    import synth_seq_pkg::*;

    localparam int TickDiv  = 4;
    localparam int GapTicks = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wrEn = 1'b0;
    logic [3:0] wrAddr = 4'd0;
    logic [3:0] wrData = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loopEn = 1'b0;
    logic [7:0] tempo = 8'd4;
    logic [3:0] len = 4'd3;
    logic [7:0] noteOut;
    logic [3:0] stepIdx;
    logic       playing;
    logic       stepStrobe;
    logic       done;

    int errorCount = 0;
    int checkCount = 0;
    bit modelCheckOn = 1'b0;

    // reference model state
    logic [3:0] mMem [16];
    bit         mPlaying = 1'b0;
    int         mStep = 0;
    int         mElapsed = 0;
    int         mT = 1;
    logic [7:0] mNote = 8'h00;
    bit         mStrobe = 1'b0;
    bit         mDone = 1'b0;

    note_step_sequencer #(
        .TICK_DIV  (TickDiv),
        .GAP_TICKS (GapTicks)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wrEn),
        .wr_addr_i     (wrAddr),
        .wr_data_i     (wrData),
        .start_i       (start),
        .stop_i        (stop),
        .loop_en_i     (loopEn),
        .tempo_i       (tempo),
        .len_i         (len),
        .note_out_o    (noteOut),
        .step_idx_o    (stepIdx),
        .playing_o     (playing),
        .step_strobe_o (stepStrobe),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // one cycle of input: set controls, cross a rising edge, drop the pulses
    task automatic applyStimulus(input bit st, input bit sp, input bit we,
                                 input logic [3:0] wa, input logic [3:0] wd);
        start  = st;
        stop   = sp;
        wrEn   = we;
        wrAddr = wa;
        wrData = wd;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        wrEn  = 1'b0;
    endtask

    task automatic writeStep(input logic [3:0] addr, input logic [3:0] code);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, code);
    endtask

    function automatic logic [7:0] keyOf(input logic [3:0] code);
        int k;
        k = int'(code[2:0]);
        return code[3] ? 8'(1 << k) : 8'h00;
    endfunction

    function automatic int periodOf(input logic [7:0] t);
        return (t == 8'd0) ? 1 : int'(t);
    endfunction

    // reference model: steps last T*TickDiv clocks, the last GapTicks*TickDiv of them silent
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mMem[i] = 4'h0;
            mPlaying = 1'b0;
            mStep    = 0;
            mElapsed = 0;
            mT       = 1;
            mNote    = 8'h00;
            mStrobe  = 1'b0;
            mDone    = 1'b0;
        end else begin
            mStrobe = 1'b0;
            mDone   = 1'b0;
            if (stop && mPlaying) begin
                mPlaying = 1'b0;
            end else if (start && !stop) begin
                mPlaying = 1'b1;
                mStep    = 0;
                mElapsed = 0;
                mT       = periodOf(tempo);
                mStrobe  = 1'b1;
            end else if (mPlaying) begin
                mElapsed++;
                if (mElapsed == mT * TickDiv) begin
                    mElapsed = 0;
                    if (mStep >= int'(len)) begin
                        if (loopEn) begin
                            mStep   = 0;
                            mT      = periodOf(tempo);
                            mStrobe = 1'b1;
                        end else begin
                            mPlaying = 1'b0;
                            mDone    = 1'b1;
                        end
                    end else begin
                        mStep++;
                        mT      = periodOf(tempo);
                        mStrobe = 1'b1;
                    end
                end
            end
            if (mPlaying && ((mT <= GapTicks) || (mElapsed / TickDiv < mT - GapTicks)))
                mNote = keyOf(mMem[mStep]);
            else
                mNote = 8'h00;
            if (wrEn) mMem[wrAddr] = wrData;
        end
    end

    // compare every DUT output with the model on each falling edge
    always @(negedge clk) begin
        if (modelCheckOn) begin
            checkOutput("model_note",    32'(noteOut),    32'(mNote));
            checkOutput("model_step",    32'(stepIdx),    32'(mStep));
            checkOutput("model_playing", 32'(playing),    32'(mPlaying));
            checkOutput("model_strobe",  32'(stepStrobe), 32'(mStrobe));
            checkOutput("model_done",    32'(done),       32'(mDone));
        end
    end

    initial begin
        logic [7:0] t1Notes [4];
        int strobeCount;
        int doneCount;
        bit st, sp, we;

        t1Notes[0] = 8'h01;
        t1Notes[1] = 8'h04;
        t1Notes[2] = 8'h10;
        t1Notes[3] = 8'h80;

        repeat (2) @(negedge clk);
        checkOutput("reset_note",    32'(noteOut),    32'h0);
        checkOutput("reset_step",    32'(stepIdx),    32'h0);
        checkOutput("reset_playing", 32'(playing),    32'h0);
        checkOutput("reset_strobe",  32'(stepStrobe), 32'h0);
        checkOutput("reset_done",    32'(done),       32'h0);
        rst_n = 1'b1;
        modelCheckOn = 1'b1;
        @(negedge clk);

        // scenario 1: four-note pattern, single shot
        $display("[TB] scenario 1: single-shot C E G C2");
        writeStep(4'd0, NOTE_C);
        writeStep(4'd1, NOTE_E);
        writeStep(4'd2, NOTE_G);
        writeStep(4'd3, NOTE_C2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 64; i++) begin
            checkOutput("t1_note", 32'(noteOut), 32'((i % 16 < 8) ? t1Notes[i / 16] : 8'h00));
            checkOutput("t1_step", 32'(stepIdx), 32'(i / 16));
            if (i % 16 == 0) checkOutput("t1_strobe", 32'(stepStrobe), 32'h1);
            @(negedge clk);
        end
        checkOutput("t1_done",    32'(done),    32'h1);
        checkOutput("t1_playing", 32'(playing), 32'h0);
        checkOutput("t1_endstep", 32'(stepIdx), 32'h3);
        checkOutput("t1_endnote", 32'(noteOut), 32'h0);
        @(negedge clk);
        checkOutput("t1_done_pulse", 32'(done), 32'h0);

        // scenario 2: same pattern looping
        $display("[TB] scenario 2: looping");
        loopEn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (64) @(negedge clk);
        checkOutput("t2_wrap_step",   32'(stepIdx),    32'h0);
        checkOutput("t2_wrap_note",   32'(noteOut),    32'h01);
        checkOutput("t2_wrap_strobe", 32'(stepStrobe), 32'h1);
        strobeCount = 0;
        doneCount   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stepStrobe) strobeCount++;
            if (done) doneCount++;
        end
        checkOutput("t2_strobes", 32'(strobeCount), 32'd2);
        checkOutput("t2_no_done", 32'(doneCount),   32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        checkOutput("t2_stopped", 32'(playing), 32'h0);
        loopEn = 1'b0;

        // scenario 3: repeated note gets a gap; tempo 1 has none
        $display("[TB] scenario 3: repeated A");
        writeStep(4'd0, NOTE_A);
        writeStep(4'd1, NOTE_A);
        len   = 4'd1;
        tempo = 8'd3;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 24; i++) begin
            checkOutput("t3_note", 32'(noteOut), 32'((i % 12 < 4) ? 8'h20 : 8'h00));
            @(negedge clk);
        end
        checkOutput("t3_done", 32'(done), 32'h1);
        @(negedge clk);
        tempo = 8'd1;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput("t3_nogap_note", 32'(noteOut), 32'h20);
            @(negedge clk);
        end
        checkOutput("t3_nogap_end", 32'(noteOut), 32'h0);
        @(negedge clk);

        // scenario 4: rest step stays silent but still strobes
        $display("[TB] scenario 4: rest step");
        len   = 4'd3;
        tempo = 8'd4;
        writeStep(4'd0, NOTE_C);
        writeStep(4'd1, NOTE_REST);
        writeStep(4'd2, NOTE_G);
        writeStep(4'd3, NOTE_C2);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 32; i++) begin
            if (i >= 16) checkOutput("t4_rest_note", 32'(noteOut), 32'h0);
            if (i == 16) begin
                checkOutput("t4_rest_strobe", 32'(stepStrobe), 32'h1);
                checkOutput("t4_rest_step",   32'(stepIdx),    32'h1);
            end
            @(negedge clk);
        end
        repeat (40) @(negedge clk);

        // scenario 5: stop and start together mid-step 2, then start alone
        $display("[TB] scenario 5: stop beats start");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (40) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        checkOutput("t5_playing", 32'(playing), 32'h0);
        checkOutput("t5_note",    32'(noteOut), 32'h0);
        checkOutput("t5_done",    32'(done),    32'h0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        checkOutput("t5_restart_strobe", 32'(stepStrobe), 32'h1);
        checkOutput("t5_restart_step",   32'(stepIdx),    32'h0);
        checkOutput("t5_restart_note",   32'(noteOut),    32'h01);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

        // scenario 6: live write to the playing step, then reset mid-play
        $display("[TB] scenario 6: live write and reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        writeStep(4'd0, NOTE_G);
        checkOutput("t6_old_note", 32'(noteOut), 32'h01);
        @(negedge clk);
        checkOutput("t6_new_note", 32'(noteOut), 32'h10);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_note",    32'(noteOut), 32'h0);
        checkOutput("t6_rst_playing", 32'(playing), 32'h0);
        checkOutput("t6_rst_step",    32'(stepIdx), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            checkOutput("t6_cleared_note", 32'(noteOut), 32'h0);
            checkOutput("t6_cleared_play", 32'(playing), 32'h1);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

        // random traffic against the model
        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 49) == 0);
            sp = ($urandom_range(0, 119) == 0);
            if (st && sp) sp = 1'b0;
            we = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) tempo = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 99) == 0) len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) loopEn = ~loopEn;
            applyStimulus(st, sp, we, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
